// File: rtl/pipe_ctrl.sv
// pipe_ctrl: Y86-64 five-stage pipeline control.
// Per-stage stall/bubble and set_cc decode, a run/drain/halt state machine,
// and saturating performance counters.
module pipe_ctrl #(
    parameter int unsigned CNT_W = 32,
    parameter logic [3:0]  RNONE = 4'hF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_dstM,
    input  logic             e_cnd,
    input  logic [1:0]       m_stat,
    input  logic [1:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             halted,
    output logic [1:0]       exc_code,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [3:0]       I_MRMOVQ = 4'h5;
    localparam logic [3:0]       I_OPQ    = 4'h6;
    localparam logic [3:0]       I_JXX    = 4'h7;
    localparam logic [3:0]       I_RET    = 4'h9;
    localparam logic [3:0]       I_POPQ   = 4'hB;
    localparam logic [1:0]       S_AOK    = 2'd0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;

    logic load_use;
    logic mispred;
    logic ret_any;
    logic exc_m;
    logic exc_w;

    // Hazard detection from the in-flight instructions.
    always_comb begin
        load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                   (E_dstM != RNONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        mispred  = (E_icode == I_JXX) && !e_cnd;
        ret_any  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        exc_m    = (m_stat != S_AOK);
        exc_w    = (W_stat != S_AOK);
    end

    // Zero-latency pipeline controls, selected by reset and machine state.
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
        if (rst) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    F_stall  = load_use | ret_any;
                    D_stall  = load_use;
                    D_bubble = mispred | (ret_any & ~load_use);
                    E_bubble = mispred | load_use;
                    M_bubble = exc_m | exc_w;
                    W_stall  = exc_w;
                    set_cc   = (E_icode == I_OPQ) & ~exc_m & ~exc_w;
                end
                DRAIN: begin
                    F_stall  = 1'b1;
                    D_bubble = 1'b1;
                    E_bubble = 1'b1;
                    M_bubble = 1'b1;
                    W_stall  = exc_w;
                end
                HALTED: begin
                    F_stall  = 1'b1;
                    D_stall  = 1'b1;
                    M_bubble = 1'b1;
                    W_stall  = 1'b1;
                end
                default: begin
                    F_stall  = 1'b0;
                end
            endcase
        end
    end

    // Run/drain/halt state machine, exception capture and performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            halted      <= 1'b0;
            exc_code    <= 2'd0;
            cyc_cnt     <= '0;
            stall_cnt   <= '0;
            mispred_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (exc_w) begin
                        state    <= HALTED;
                        halted   <= 1'b1;
                        exc_code <= W_stat;
                    end else if (exc_m) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (exc_w) begin
                        state    <= HALTED;
                        halted   <= 1'b1;
                        exc_code <= W_stat;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= RUN;
                end
            endcase

            if ((state != HALTED) && (cyc_cnt != CNT_MAX))
                cyc_cnt <= cyc_cnt + CNT_W'(1);
            if ((state == RUN) && F_stall && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if ((state == RUN) && mispred && (mispred_cnt != CNT_MAX))
                mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit for the five-stage Y86-64 pipeline. It derives the per-stage stall/bubble controls and the execute stage's condition-code write enable from the icodes, register IDs, branch outcome and status values of the in-flight instructions. A registered run/drain/halt state machine freezes the machine cleanly on an exception or halt. Saturating performance counters report cycles, stall cycles and branch mispredicts.

Parameters:
CNT_W, 32, width of each performance counter
RNONE, 4'hF, register ID meaning "no register"

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
D_icode  input  4  icode in decode stage
E_icode  input  4  icode in execute stage
M_icode  input  4  icode in memory stage
d_srcA  input  4  decode srcA register ID
d_srcB  input  4  decode srcB register ID
E_dstM  input  4  execute-stage dstM register ID
e_cnd  input  1  branch/cmov condition from execute
m_stat  input  2  memory-stage status: 0 AOK, 1 HLT, 2 ADR, 3 INS
W_stat  input  2  write-back-stage status, same encoding
F_stall  output  1  hold fetch PC register
D_stall  output  1  hold decode pipeline register
D_bubble  output  1  load nop into decode register
E_bubble  output  1  load nop into execute register
M_bubble  output  1  load nop into memory register
W_stall  output  1  hold write-back register
set_cc  output  1  condition-code write enable for execute
halted  output  1  registered; machine frozen
exc_code  output  2  registered; W_stat captured on entry to HALTED
cyc_cnt  output  CNT_W  cycles spent outside HALTED
stall_cnt  output  CNT_W  cycles with F_stall=1 in RUN
mispred_cnt  output  CNT_W  mispredicted jXX count

Behaviour:
- Hazard terms are combinational from the inputs:
  - load_use = (E_icode==5 or 11) and E_dstM!=RNONE and (E_dstM==d_srcA or E_dstM==d_srcB).
  - mispred = (E_icode==7 and e_cnd==0).
  - ret_any = 9 in any of D_icode, E_icode, M_icode.
  - exc_m = m_stat!=0.
  - exc_w = W_stat!=0.
- RUN outputs:
  - F_stall = load_use | ret_any.
  - D_stall = load_use.
  - D_bubble = mispred | (ret_any & ~load_use).
  - E_bubble = mispred | load_use.
  - M_bubble = exc_m | exc_w.
  - W_stall = exc_w.
  - set_cc = (E_icode==6) & ~exc_m & ~exc_w.
- FSM states: RUN, DRAIN, HALTED. State is registered. Outputs are a function of the current state and the current inputs.
  - RUN -> HALTED if exc_w.
  - RUN -> DRAIN else if exc_m.
  - RUN stays RUN otherwise.
  - DRAIN: F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1, set_cc=0, D_stall=0, W_stall=exc_w. Goes to HALTED when exc_w. Otherwise stays in DRAIN; a bubbled M keeps m_stat at AOK.
  - HALTED: F_stall=1, D_stall=1, W_stall=1, D_bubble=0, E_bubble=0, M_bubble=1, set_cc=0. Exits only via rst.
- halted=1 from the cycle after entry to HALTED. On the entering edge, exc_code <= W_stat; it then holds.
- Counters (registered, saturating at all-ones, never wrap):
  - cyc_cnt +1 every cycle the state is not HALTED.
  - stall_cnt +1 on each RUN cycle with F_stall=1.
  - mispred_cnt +1 on each RUN cycle with mispred=1.
- Reset: while rst=1, state <= RUN, halted <= 0, exc_code <= 0, all counters <= 0. Combinational outputs during the rst cycle are F_stall=0, D_stall=0, W_stall=0, D_bubble=1, E_bubble=1, M_bubble=1, set_cc=0. Reset asserted in any state, including mid-DRAIN, returns to RUN on the next edge.
- Simultaneous events:
  - load_use and ret_any: D_stall=1, D_bubble=0.
  - mispred and ret_any (ret in D): D_bubble=1, E_bubble=1, F_stall=1.
  - exc_m and exc_w together in RUN: go directly to HALTED.
  - mispred and load_use are mutually exclusive by icode.
- Latency: control outputs are zero-cycle (same cycle as inputs). State and counters update one cycle later.

Test Plan:
- Load-use: E_icode=5, E_dstM=3, d_srcB=3, all stat 0 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. Next edge stall_cnt=1.
- Mispredict: E_icode=7, e_cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0, set_cc=0. mispred_cnt goes 0->1. With e_cnd=1 -> all controls 0.
- ret sequence: D_icode=9, then E_icode=9, then M_icode=9 over 3 cycles -> F_stall=1 and D_bubble=1 on each cycle; stall_cnt=3. Load-use in the same cycle as ret in D -> D_stall=1, D_bubble=0.
- OPq with exceptions: E_icode=6, stats 0 -> set_cc=1. Same with m_stat=2 -> set_cc=0, M_bubble=1, state DRAIN next cycle. Then W_stat=2 -> HALTED, halted=1, exc_code=2, cyc_cnt frozen.
- HALT path: RUN with W_stat=1 and m_stat=0 -> HALTED directly, exc_code=1; F_stall=D_stall=W_stall=1 held for 10 cycles; rst for 1 cycle -> RUN, counters 0, halted=0.
- Saturation: CNT_W=4, 20 consecutive mispredict cycles -> mispred_cnt=15, cyc_cnt=15, no wrap.
